// File: rtl/fifo_rd_pkg.sv
// Shared types and default sizes for the FIFO burst reader.
package fifo_rd_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO pop port plus the valid/ready output stream of the burst reader.
interface fifo_burst_reader_if import fifo_rd_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             fifo_read_en;
    logic             fifo_empty_n;
    logic [WIDTH-1:0] fifo_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        output fifo_read_en,
        input  fifo_empty_n,
        input  fifo_data,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    modport slave (
        input  fifo_read_en,
        output fifo_empty_n,
        output fifo_data,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order output buffer between the FIFO read port and the stream.
module fifo_rd_skid import fifo_rd_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             last0;
    logic             last1;
    logic             pop;

    assign pop = m_valid && m_ready;

    // Head entry drives the stream; a pop shifts entry 1 forward, a push fills the first free slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ   <= 2'd0;
            data0 <= '0;
            data1 <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        data0 <= push_data;
                        last0 <= push_last;
                    end else begin
                        data1 <= push_data;
                        last1 <= push_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    data0 <= data1;
                    last0 <= last1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        data0 <= push_data;
                        last0 <= push_last;
                    end else begin
                        data0 <= data1;
                        last0 <= last1;
                        data1 <= push_data;
                        last1 <= push_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Stream view of the head entry.
    always_comb begin
        m_valid = (occ != 2'd0);
        m_data  = data0;
        m_last  = (occ != 2'd0) && last0;
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains burst_len words from the FIFO per start command onto a valid/ready stream.
module fifo_burst_reader import fifo_rd_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] words_left,
    fifo_burst_reader_if.master bus
);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] issue_cnt;
    logic             inflight;
    logic             inflight_last;
    logic [1:0]       occ;
    logic             hs;
    logic             pop;
    logic [2:0]       slots;
    logic             m_valid_w;
    logic [WIDTH-1:0] m_data_w;
    logic             m_last_w;

    // Buffer slots still claimed once this cycle's handshake retires; keeps the in-flight word a home.
    assign hs    = m_valid_w && bus.m_ready;
    assign slots = 3'(occ) + 3'(inflight) - 3'(hs);
    assign pop   = !rst && (state == FETCH) && bus.fifo_empty_n
                   && (issue_cnt != '0) && (slots < 3'd2);

    assign bus.fifo_read_en = pop;
    assign bus.m_valid      = m_valid_w;
    assign bus.m_data       = m_data_w;
    assign bus.m_last       = m_last_w;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the final handshake jumps straight to DONE so done follows it immediately.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (burst_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (hs && (words_left == LEN_W'(1))) begin
                    state_nxt = DONE;
                end else if ((issue_cnt == '0) || (pop && (issue_cnt == LEN_W'(1)))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((hs && (words_left == LEN_W'(1)))
                    || (!inflight && (occ == 2'd0) && (words_left == '0))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            FETCH, DRAIN: busy = 1'b1;
            DONE:         done = 1'b1;
            default: begin
            end
        endcase
    end

    // Issue/accept counters and the one-deep in-flight tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt     <= '0;
            words_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= pop;
            inflight_last <= pop && (issue_cnt == LEN_W'(1));
            if ((state == IDLE) && start) begin
                issue_cnt  <= burst_len;
                words_left <= burst_len;
            end else begin
                if (pop && (issue_cnt != '0)) begin
                    issue_cnt <= issue_cnt - LEN_W'(1);
                end
                if (hs && (words_left != '0)) begin
                    words_left <= words_left - LEN_W'(1);
                end
            end
        end
    end

    fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (bus.fifo_data),
        .push_last (inflight_last),
        .m_ready   (bus.m_ready),
        .m_valid   (m_valid_w),
        .m_data    (m_data_w),
        .m_last    (m_last_w),
        .occ       (occ)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench: FIFO model, stream scoreboard and per-scenario tasks.
module tb_fifo_burst_reader;
    import fifo_rd_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] burst_len = '0;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] words_left;

    fifo_burst_reader_if #(.WIDTH(WIDTH)) bus ();

    fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
        .words_left (words_left),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural FIFO: words written by tasks, data_out valid the cycle after a pop.
    logic [WIDTH-1:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    bit fifo_flush = 1'b0;

    assign bus.fifo_empty_n = (wr_ptr != rd_ptr);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_read_en && bus.fifo_empty_n) begin
            bus.fifo_data <= mem[8'(rd_ptr)];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // Stream monitor: accepted words, pop counts, stall stability, outstanding words.
    int pops = 0;
    int acc = 0;
    int pop_empty_err = 0;
    int stab_err = 0;
    int outst = 0;
    logic [WIDTH:0] got_q[$];
    bit prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
            outst      <= 0;
        end else begin
            if (bus.fifo_read_en) begin
                pops <= pops + 1;
                if (!bus.fifo_empty_n) pop_empty_err <= pop_empty_err + 1;
            end
            if (bus.m_valid && bus.m_ready) begin
                got_q.push_back({bus.m_last, bus.m_data});
                acc <= acc + 1;
            end
            if (prev_stall && (bus.m_valid !== 1'b1 || bus.m_data !== prev_data || bus.m_last !== prev_last))
                stab_err <= stab_err + 1;
            prev_stall <= bus.m_valid && !bus.m_ready;
            prev_data  <= bus.m_data;
            prev_last  <= bus.m_last;
            outst      <= outst + int'(bus.fifo_read_en) - int'(bus.m_valid && bus.m_ready);
        end
    end

    int acc0, got0, pop0, se0, pe0;
    logic [WIDTH-1:0] feed_q[$];

    task automatic push_word(input logic [WIDTH-1:0] w);
        mem[8'(wr_ptr)] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic logic ready_val(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return ((k % 4) == 0) || ((k % 4) == 3);
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    task automatic issue_start(input int len);
        @(negedge clk);
        acc0 = acc; got0 = got_q.size(); pop0 = pops; se0 = stab_err; pe0 = pop_empty_err;
        start = 1'b1;
        burst_len = LEN_W'(len);
    endtask

    // Runs cycles after the start cycle until done, feeding feed_q into the FIFO with random gaps.
    task automatic run_until_done(input int len, input int mode, input int gap_max, input int poke,
                                  output int wl_bad, output int max_out, output bit timed_out);
        int k, gap;
        bit fin;
        wl_bad = 0; max_out = 0; timed_out = 1'b0; k = 1; gap = 0; fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            start = (k == poke);
            if (k == poke) burst_len = LEN_W'(9);
            if (feed_q.size() != 0) begin
                if (gap == 0) begin
                    push_word(feed_q.pop_front());
                    gap = int'($urandom_range(0, gap_max));
                end else begin
                    gap--;
                end
            end
            bus.m_ready = ready_val(mode, k);
            #1;
            if (outst > max_out) max_out = outst;
            if (words_left !== LEN_W'(len - (acc - acc0))) wl_bad++;
            if (done === 1'b1) fin = 1'b1;
            else if (k >= 300) begin timed_out = 1'b1; fin = 1'b1; end
            k++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; bus.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (words_left !== '0) begin errors++; $display("FAIL reset_words_left: got %0d want 0", words_left); end
        checks++; if (bus.fifo_read_en !== 1'b0) begin errors++; $display("FAIL reset_read_en: got %b want 0", bus.fifo_read_en); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
        checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b want 0", bus.m_last); end
        checks++; if (bus.m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %0h want 0", bus.m_data); end
        rst = 1'b0;
    endtask

    task automatic test_basic_timing;
        logic exp_valid;
        @(negedge clk);
        for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
        bus.m_ready = 1'b1;
        issue_start(4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            exp_valid = (c >= 3) && (c <= 6);
            checks++; if (bus.fifo_read_en !== ((c >= 1) && (c <= 4))) begin errors++; $display("FAIL basic_read_en c%0d: got %b", c, bus.fifo_read_en); end
            checks++; if (bus.m_valid !== exp_valid) begin errors++; $display("FAIL basic_m_valid c%0d: got %b want %b", c, bus.m_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (bus.m_data !== 32'hA0 + 32'(c - 3)) begin errors++; $display("FAIL basic_m_data c%0d: got %0h want %0h", c, bus.m_data, 32'hA0 + 32'(c - 3)); end
            end
            checks++; if (bus.m_last !== (c == 6)) begin errors++; $display("FAIL basic_m_last c%0d: got %b", c, bus.m_last); end
            checks++; if (done !== (c == 7)) begin errors++; $display("FAIL basic_done c%0d: got %b", c, done); end
            checks++; if (busy !== ((c >= 1) && (c <= 6))) begin errors++; $display("FAIL basic_busy c%0d: got %b", c, busy); end
        end
    endtask

    task automatic test_zero_len;
        bus.m_ready = 1'b1;
        issue_start(0);
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++; if (bus.m_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL zero_quiet c%0d: m_valid %b done %b want 0 0", c, bus.m_valid, done); end
        end
        checks++; if (pops - pop0 !== 0) begin errors++; $display("FAIL zero_pops: got %0d want 0", pops - pop0); end
    endtask

    task automatic test_empty_stall;
        int wl_bad, max_out;
        bit to;
        logic [WIDTH-1:0] w [3];
        bus.m_ready = 1'b1;
        issue_start(3);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            checks++; if (bus.fifo_read_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL empty_stall c%0d: read_en %b busy %b want 0 1", k, bus.fifo_read_en, busy); end
        end
        for (int i = 0; i < 3; i++) begin w[i] = $urandom; feed_q.push_back(w[i]); end
        run_until_done(3, 0, 0, -1, wl_bad, max_out, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL empty_timeout: got %b want 0", to); end
        checks++; if (got_q.size() - got0 !== 3) begin errors++; $display("FAIL empty_count: got %0d want 3", got_q.size() - got0); end
        for (int i = 0; i < 3 && got0 + i < got_q.size(); i++) begin
            checks++; if (got_q[got0 + i] !== {(i == 2), w[i]}) begin errors++; $display("FAIL empty_word%0d: got %0h want %0h", i, got_q[got0 + i], {(i == 2), w[i]}); end
        end
        checks++; if (pop_empty_err - pe0 !== 0) begin errors++; $display("FAIL empty_pop_on_empty: got %0d want 0", pop_empty_err - pe0); end
        checks++; if (wl_bad !== 0) begin errors++; $display("FAIL empty_words_left: got %0d bad cycles want 0", wl_bad); end
    endtask

    task automatic test_backpressure;
        int wl_bad, max_out;
        bit to;
        logic [WIDTH-1:0] w [6];
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin w[i] = $urandom; push_word(w[i]); end
        bus.m_ready = 1'b1;
        issue_start(6);
        run_until_done(6, 1, 0, -1, wl_bad, max_out, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b want 0", to); end
        checks++; if (got_q.size() - got0 !== 6) begin errors++; $display("FAIL bp_count: got %0d want 6", got_q.size() - got0); end
        for (int i = 0; i < 6 && got0 + i < got_q.size(); i++) begin
            checks++; if (got_q[got0 + i] !== {(i == 5), w[i]}) begin errors++; $display("FAIL bp_word%0d: got %0h want %0h", i, got_q[got0 + i], {(i == 5), w[i]}); end
        end
        checks++; if (stab_err - se0 !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stab_err - se0); end
        checks++; if (max_out > 2) begin errors++; $display("FAIL bp_ahead: got %0d pops ahead want <=2", max_out); end
        checks++; if (wl_bad !== 0) begin errors++; $display("FAIL bp_words_left: got %0d bad cycles want 0", wl_bad); end
    endtask

    task automatic test_reset_mid_burst;
        int k, wl_bad, max_out;
        bit to;
        logic [WIDTH-1:0] w [2];
        @(negedge clk);
        for (int i = 0; i < 5; i++) push_word($urandom);
        bus.m_ready = 1'b1;
        issue_start(5);
        k = 0;
        while ((acc - acc0) < 2 && k < 30) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            k++;
        end
        checks++; if (acc - acc0 !== 2) begin errors++; $display("FAIL rstmid_prefix: got %0d accepted want 2", acc - acc0); end
        rst = 1'b1; fifo_flush = 1'b1;
        @(negedge clk);
        rst = 1'b0; fifo_flush = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_status: busy %b done %b want 0 0", busy, done); end
        checks++; if (words_left !== '0) begin errors++; $display("FAIL rstmid_words_left: got %0d want 0", words_left); end
        checks++; if (bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 || bus.m_data !== '0) begin errors++; $display("FAIL rstmid_stream: valid %b last %b data %0h want 0 0 0", bus.m_valid, bus.m_last, bus.m_data); end
        checks++; if (bus.fifo_read_en !== 1'b0) begin errors++; $display("FAIL rstmid_read_en: got %b want 0", bus.fifo_read_en); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done c%0d: got %b want 0", c, done); end
        end
        for (int i = 0; i < 2; i++) begin w[i] = $urandom; feed_q.push_back(w[i]); end
        issue_start(2);
        run_until_done(2, 0, 1, -1, wl_bad, max_out, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rstmid_timeout: got %b want 0", to); end
        checks++; if (got_q.size() - got0 !== 2) begin errors++; $display("FAIL rstmid_count: got %0d want 2", got_q.size() - got0); end
        for (int i = 0; i < 2 && got0 + i < got_q.size(); i++) begin
            checks++; if (got_q[got0 + i] !== {(i == 1), w[i]}) begin errors++; $display("FAIL rstmid_word%0d: got %0h want %0h", i, got_q[got0 + i], {(i == 1), w[i]}); end
        end
    endtask

    task automatic test_start_while_busy;
        int wl_bad, max_out;
        bit to;
        logic [WIDTH-1:0] w [4];
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin w[i] = $urandom; push_word(w[i]); end
        bus.m_ready = 1'b1;
        issue_start(4);
        run_until_done(4, 1, 0, 2, wl_bad, max_out, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL busy_start_timeout: got %b want 0", to); end
        checks++; if (wl_bad !== 0) begin errors++; $display("FAIL busy_start_words_left: got %0d bad cycles want 0", wl_bad); end
        checks++; if (got_q.size() - got0 !== 4) begin errors++; $display("FAIL busy_start_count: got %0d want 4", got_q.size() - got0); end
        for (int i = 0; i < 4 && got0 + i < got_q.size(); i++) begin
            checks++; if (got_q[got0 + i] !== {(i == 3), w[i]}) begin errors++; $display("FAIL busy_start_word%0d: got %0h want %0h", i, got_q[got0 + i], {(i == 3), w[i]}); end
        end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_after: busy %b want 0", busy); end
        checks++; if (pops - pop0 !== 4) begin errors++; $display("FAIL busy_start_pops: got %0d want 4", pops - pop0); end
    endtask

    task automatic test_random_bursts;
        int len, wl_bad, max_out, nbad;
        bit to;
        logic [WIDTH:0] exp_q[$];
        for (int b = 0; b < 12; b++) begin
            len = int'($urandom_range(0, 10));
            exp_q.delete();
            for (int i = 0; i < len; i++) begin
                feed_q.push_back($urandom);
                exp_q.push_back({(i == len - 1), feed_q[i]});
            end
            issue_start(len);
            run_until_done(len, 2, 2, -1, wl_bad, max_out, to);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout: got %b want 0", b, to); end
            checks++; if (got_q.size() - got0 !== len) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", b, got_q.size() - got0, len); end
            nbad = 0;
            for (int i = 0; i < len && got0 + i < got_q.size(); i++)
                if (got_q[got0 + i] !== exp_q[i]) nbad++;
            checks++; if (nbad !== 0) begin errors++; $display("FAIL rand%0d_data: got %0d wrong words want 0", b, nbad); end
            checks++; if (wl_bad !== 0 || stab_err - se0 !== 0 || pop_empty_err - pe0 !== 0 || max_out > 2) begin
                errors++; $display("FAIL rand%0d_rules: words_left %0d stable %0d pop_empty %0d ahead %0d want 0 0 0 <=2", b, wl_bad, stab_err - se0, pop_empty_err - pe0, max_out);
            end
            checks++; if (pops - pop0 !== len) begin errors++; $display("FAIL rand%0d_pops: got %0d want %0d", b, pops - pop0, len); end
        end
    endtask

    initial begin
        bus.m_ready = 1'b0;
        test_reset();
        test_basic_timing();
        test_zero_len();
        test_empty_stall();
        test_backpressure();
        test_reset_mid_burst();
        test_start_while_busy();
        test_random_bursts();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
